imem_arbiter: RTL and testbench
===============================

IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 SHALL provide parameter AW, default 10, meaning word-index width of the instruction memory (2^AW words).
REQ-002 SHALL provide parameter DW, default 32, meaning instruction/data word width.
REQ-003 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL provide port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL provide ports fetch_req input 1, fetch_addr input 32 (byte address), fetch_gnt output 1, fetch_rvalid output 1, fetch_rdata output DW, fetch_err output 1.
REQ-006 SHALL provide ports ld_req input 1, ld_we input 1, ld_lock input 1, ld_addr input 32 (byte address), ld_wdata input DW, ld_gnt output 1, ld_rvalid output 1, ld_rdata output DW.
REQ-007 SHALL provide memory-side ports mem_en output 1, mem_we output 1, mem_addr output AW, mem_wdata output DW, mem_rdata input DW; memory returns read data the cycle after mem_en=1 with mem_we=0.

Function
REQ-008 SHALL grant at most one requester per cycle; a grant is combinational from the current-cycle req and arbiter state.
REQ-009 SHALL drive mem_en=1 in a granted cycle, with mem_addr = granted byte address bits [AW+1:2]; address bits [1:0] SHALL be ignored.
REQ-010 SHALL drive mem_we=ld_we and mem_wdata=ld_wdata only when the loader is granted; mem_we=0 otherwise.
REQ-011 SHALL assert the granted requester's rvalid exactly one cycle after a granted read, with rdata = mem_rdata; loader writes SHALL produce no ld_rvalid.
REQ-012 SHALL treat a fetch whose address bits [31:AW+2] are nonzero as out-of-range: grant it, keep mem_en=0, and one cycle later assert fetch_rvalid=1, fetch_err=1, fetch_rdata=0.
REQ-013 SHALL drop out-of-range loader accesses silently (granted, no memory access, ld_rvalid=0).
REQ-014 SHALL hold rdata outputs at their last value when the corresponding rvalid=0.
REQ-015 SHALL implement FSM states ARB and LOCKED; ARB arbitrates per REQ-025/026; ARB->LOCKED when the loader is granted with ld_lock=1; LOCKED->ARB on the first cycle with ld_lock=0.
REQ-016 SHALL, in LOCKED, grant only the loader (ld_gnt=ld_req) and hold fetch_gnt=0 regardless of fetch_req.
REQ-017 SHALL, on the LOCKED->ARB cycle, already arbitrate normally (no idle bubble).
REQ-018 SHALL issue no grants and no memory access when neither requester is requesting; rvalid outputs SHALL be 0 on the following cycle.
REQ-019 SHALL not require requesters to hold req after grant; a de-asserted req without grant is simply not served.

Reset
REQ-020 SHALL, on reset, force state ARB, round-robin pointer to "fetch preferred", and all registered outputs (fetch_rvalid, fetch_err, ld_rvalid, fetch_rdata, ld_rdata) to 0.
REQ-021 SHALL, in a reset cycle, drive fetch_gnt=0, ld_gnt=0, mem_en=0, mem_we=0.
REQ-022 SHALL discard any read in flight when reset asserts: no rvalid follows the reset cycle.
REQ-023 SHALL release from LOCKED on reset even if ld_lock=1.

Configuration
REQ-024 SHALL select the arbitration policy with macro IMEM_ARB_ROUND_ROBIN_EN.
REQ-025 SHALL, with IMEM_ARB_ROUND_ROBIN_EN defined, resolve simultaneous requests in favour of the requester not granted in the most recent contended cycle; the pointer updates only on contended cycles.
REQ-026 SHALL, without IMEM_ARB_ROUND_ROBIN_EN, use fixed priority: loader always wins over fetch.

Verification
REQ-027 Fetch-only read: memory word 3 = 0x2001000A, fetch_req=1, fetch_addr=0x0C -> fetch_gnt=1, mem_addr=3 same cycle; next cycle fetch_rvalid=1, fetch_rdata=0x2001000A, fetch_err=0.
REQ-028 Out-of-range: fetch_addr=0x00001000 (AW=10) -> fetch_gnt=1, mem_en=0; next cycle fetch_rvalid=1, fetch_err=1, fetch_rdata=0.
REQ-029 Contention, IMEM_ARB_ROUND_ROBIN_EN defined: both req high for 4 cycles after reset -> grants fetch, ld, fetch, ld; without the macro -> ld all 4 cycles.
REQ-030 Lock: loader write ld_addr=0x10, ld_wdata=0x12345678, ld_lock=1 for 3 cycles with fetch_req=1 -> fetch_gnt=0 for those 3 cycles, mem_we=1; fetch granted the cycle ld_lock drops; subsequent fetch of 0x10 returns 0x12345678.
REQ-031 Reset mid-read: grant fetch read, assert reset next cycle -> fetch_rvalid=0 in that cycle and the one after; state ARB.

Source files
------------

// File: rtl/imem_arbiter.sv
// imem_arbiter: arbitrates fetch and loader ports onto one instruction SRAM.
// Ports: clk/reset, fetch_*, ld_*, mem_*; IMEM_ARB_ROUND_ROBIN_EN selects round-robin arbitration.
module imem_arbiter #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          fetch_req,
  input  logic [31:0]   fetch_addr,
  output logic          fetch_gnt,
  output logic          fetch_rvalid,
  output logic [DW-1:0] fetch_rdata,
  output logic          fetch_err,
  input  logic          ld_req,
  input  logic          ld_we,
  input  logic          ld_lock,
  input  logic [31:0]   ld_addr,
  input  logic [DW-1:0] ld_wdata,
  output logic          ld_gnt,
  output logic          ld_rvalid,
  output logic [DW-1:0] ld_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic {ARB, LOCKED} state_t;

  state_t        state;
  logic          locked;
  logic          contend;
  logic          pick_ld;
  logic          f_oor;
  logic          l_oor;
  logic          f_pend;
  logic          f_err_q;
  logic          l_pend;
  logic [DW-1:0] f_hold;
  logic [DW-1:0] l_hold;

  assign f_oor = (fetch_addr >> (AW + 2)) != 32'd0;
  assign l_oor = (ld_addr >> (AW + 2)) != 32'd0;

  // A dropped ld_lock releases the lock in the same cycle.
  assign locked  = (state == LOCKED) && ld_lock;
  assign contend = fetch_req && ld_req && !locked;

`ifdef IMEM_ARB_ROUND_ROBIN_EN
  // 1: loader preferred on the next contended cycle.
  logic rr_ld;

  assign pick_ld = rr_ld;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ld <= 1'b0;
    end else if (contend) begin
      rr_ld <= !rr_ld;
    end
  end
`else
  assign pick_ld = 1'b1;
`endif

  always_comb begin
    fetch_gnt = 1'b0;
    ld_gnt    = 1'b0;
    if (!reset) begin
      if (locked) begin
        ld_gnt = ld_req;
      end else if (contend) begin
        ld_gnt    = pick_ld;
        fetch_gnt = !pick_ld;
      end else begin
        fetch_gnt = fetch_req;
        ld_gnt    = ld_req;
      end
    end
  end

  assign mem_en    = (fetch_gnt && !f_oor) || (ld_gnt && !l_oor);
  assign mem_we    = ld_gnt && !l_oor && ld_we;
  assign mem_addr  = ld_gnt ? ld_addr[AW+1:2] : fetch_addr[AW+1:2];
  assign mem_wdata = ld_gnt ? ld_wdata : '0;

  // Gating with reset kills a read that was in flight when reset rose.
  assign fetch_rvalid = f_pend && !reset;
  assign fetch_err    = fetch_rvalid && f_err_q;
  assign ld_rvalid    = l_pend && !reset;

  assign fetch_rdata = fetch_rvalid ? (f_err_q ? '0 : mem_rdata) : f_hold;
  assign ld_rdata    = ld_rvalid ? mem_rdata : l_hold;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ARB;
      f_pend  <= 1'b0;
      f_err_q <= 1'b0;
      l_pend  <= 1'b0;
      f_hold  <= '0;
      l_hold  <= '0;
    end else begin
      state   <= (locked || (ld_gnt && ld_lock)) ? LOCKED : ARB;
      f_pend  <= fetch_gnt;
      f_err_q <= fetch_gnt && f_oor;
      l_pend  <= ld_gnt && !l_oor && !ld_we;
      if (fetch_rvalid) begin
        f_hold <= fetch_rdata;
      end
      if (ld_rvalid) begin
        l_hold <= ld_rdata;
      end
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: scoreboard bench for imem_arbiter with a behavioural SRAM.
// Grants are checked per cycle; read returns are queued and checked on return.
module tb_imem_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          fetch_req;
  logic [31:0]   fetch_addr;
  logic          fetch_gnt;
  logic          fetch_rvalid;
  logic [DW-1:0] fetch_rdata;
  logic          fetch_err;
  logic          ld_req;
  logic          ld_we;
  logic          ld_lock;
  logic [31:0]   ld_addr;
  logic [DW-1:0] ld_wdata;
  logic          ld_gnt;
  logic          ld_rvalid;
  logic [DW-1:0] ld_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  imem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .fetch_req    (fetch_req),
    .fetch_addr   (fetch_addr),
    .fetch_gnt    (fetch_gnt),
    .fetch_rvalid (fetch_rvalid),
    .fetch_rdata  (fetch_rdata),
    .fetch_err    (fetch_err),
    .ld_req       (ld_req),
    .ld_we        (ld_we),
    .ld_lock      (ld_lock),
    .ld_addr      (ld_addr),
    .ld_wdata     (ld_wdata),
    .ld_gnt       (ld_gnt),
    .ld_rvalid    (ld_rvalid),
    .ld_rdata     (ld_rdata),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] d;
    logic        e;
  } exp_t;

  exp_t          fq[$];
  exp_t          lq[$];
  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] ref_mem [2**AW];
  int            cyc = 0;
  int            n_vec = 0;
  int            n_err = 0;
  logic [31:0]   f_last = '0;
  logic [31:0]   l_last = '0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else mem_rdata <= mem[mem_addr];
    end
  end

  always @(negedge clk) begin
    exp_t e;
    logic rv;
    rv = fq.size() > 0 && fq[0].cyc == cyc;
    chk("fetch_rvalid", {31'd0, fetch_rvalid}, {31'd0, rv});
    if (rv) begin
      e = fq.pop_front();
      chk("fetch_rdata", fetch_rdata, e.d);
      chk("fetch_err", {31'd0, fetch_err}, {31'd0, e.e});
      f_last = e.d;
    end else if (!reset) begin
      chk("fetch_rdata_hold", fetch_rdata, f_last);
      chk("fetch_err_idle", {31'd0, fetch_err}, 32'd0);
    end
    rv = lq.size() > 0 && lq[0].cyc == cyc;
    chk("ld_rvalid", {31'd0, ld_rvalid}, {31'd0, rv});
    if (rv) begin
      e = lq.pop_front();
      chk("ld_rdata", ld_rdata, e.d);
      l_last = e.d;
    end else if (!reset) begin
      chk("ld_rdata_hold", ld_rdata, l_last);
    end
    if (reset) begin
      f_last = '0;
      l_last = '0;
    end
  end

  task automatic step(input logic rst, input logic fr,
                      input logic [31:0] fa, input logic lr,
                      input logic lw, input logic lk,
                      input logic [31:0] la, input logic [31:0] wd,
                      input logic efg, input logic elg);
    logic fo;
    logic lo;
    @(posedge clk);
    #1;
    reset      = rst;
    fetch_req  = fr;
    fetch_addr = fa;
    ld_req     = lr;
    ld_we      = lw;
    ld_lock    = lk;
    ld_addr    = la;
    ld_wdata   = wd;
    if (rst) begin
      fq.delete();
      lq.delete();
    end
    @(negedge clk);
    fo = (fa >> 12) != 0;
    lo = (la >> 12) != 0;
    chk("fetch_gnt", {31'd0, fetch_gnt}, {31'd0, efg});
    chk("ld_gnt", {31'd0, ld_gnt}, {31'd0, elg});
    chk("mem_en", {31'd0, mem_en},
        {31'd0, (efg && !fo) || (elg && !lo)});
    chk("mem_we", {31'd0, mem_we}, {31'd0, elg && !lo && lw});
    if (efg && !fo) chk("mem_addr_f", {22'd0, mem_addr}, {22'd0, fa[11:2]});
    if (elg && !lo) chk("mem_addr_l", {22'd0, mem_addr}, {22'd0, la[11:2]});
    if (efg) fq.push_back('{cyc + 1, fo ? 32'd0 : ref_mem[fa[11:2]], fo});
    if (elg && !lo) begin
      if (lw) begin
        chk("mem_wdata", mem_wdata, wd);
        ref_mem[la[11:2]] = wd;
      end else begin
        lq.push_back('{cyc + 1, ref_mem[la[11:2]], 1'b0});
      end
    end
  endtask

  task automatic idle(input logic rst);
    step(rst, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1; fetch_req = 0; fetch_addr = 0; ld_req = 0;
    ld_we = 0; ld_lock = 0; ld_addr = 0; ld_wdata = 0;
    for (int i = 0; i < 2**AW; i++) begin
      mem[i]     = 32'h1000_0000 + i;
      ref_mem[i] = 32'h1000_0000 + i;
    end
    mem[3] = 32'h2001_000A; ref_mem[3] = 32'h2001_000A;
    mem[2] = 32'hA5A5_0002; ref_mem[2] = 32'hA5A5_0002;

    // reset: grants suppressed even with requests
    step(1, 1, 32'h0C, 1, 0, 0, 32'h08, 0, 0, 0);
    idle(0);
    // fetch-only reads, low byte bits ignored
    step(0, 1, 32'h0C, 0, 0, 0, 0, 0, 1, 0);
    step(0, 1, 32'h0F, 0, 0, 0, 0, 0, 1, 0);
    // out-of-range fetch
    step(0, 1, 32'h1000, 0, 0, 0, 0, 0, 1, 0);
    idle(0);
    idle(0);
    // loader write then read back
    step(0, 0, 0, 1, 1, 0, 32'h14, 32'hCAFE_F00D, 0, 1);
    step(0, 0, 0, 1, 0, 0, 32'h14, 0, 0, 1);
    // out-of-range loader write is dropped
    step(0, 0, 0, 1, 1, 0, 32'h2000, 32'hDEAD_BEEF, 0, 1);
    step(0, 0, 0, 1, 0, 0, 32'h0, 0, 0, 1);
    step(0, 0, 0, 1, 0, 0, 32'h2000, 0, 0, 1);
    idle(0);

    // contention right after reset
    idle(1);
    for (int i = 0; i < 4; i++) begin
`ifdef IMEM_ARB_ROUND_ROBIN_EN
      step(0, 1, 32'h0C, 1, 0, 0, 32'h08, 0, (i % 2) == 0, (i % 2) == 1);
`else
      step(0, 1, 32'h0C, 1, 0, 0, 32'h08, 0, 0, 1);
`endif
    end
    idle(0);

    // lock sequence
    idle(1);
`ifdef IMEM_ARB_ROUND_ROBIN_EN
    step(0, 1, 32'h0C, 1, 0, 0, 32'h08, 0, 1, 0);
`else
    step(0, 1, 32'h0C, 1, 0, 0, 32'h08, 0, 0, 1);
`endif
    for (int i = 0; i < 3; i++)
      step(0, 1, 32'h0C, 1, 1, 1, 32'h10, 32'h1234_5678, 0, 1);
    step(0, 1, 32'h0C, 0, 0, 1, 32'h10, 0, 0, 0);
    step(0, 1, 32'h0C, 0, 0, 0, 32'h10, 0, 1, 0);
    step(0, 1, 32'h10, 0, 0, 0, 0, 0, 1, 0);
    idle(0);
    chk("lock_word", ref_mem[4], 32'h1234_5678);

    // reset while a read is in flight
    step(0, 1, 32'h0C, 0, 0, 0, 0, 0, 1, 0);
    idle(1);
    idle(0);
    step(0, 1, 32'h08, 0, 0, 0, 0, 0, 1, 0);

    // reset releases a held lock
    step(0, 0, 0, 1, 1, 1, 32'h18, 32'h0BAD_CAFE, 0, 1);
    step(1, 1, 32'h0C, 0, 0, 1, 0, 0, 0, 0);
    step(0, 1, 32'h0C, 0, 0, 1, 0, 0, 1, 0);
    idle(0);
    idle(0);

    chk("fq_drained", fq.size(), 0);
    chk("lq_drained", lq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
